// File: rtl/reg_ops_pkg.sv
// Shared definitions for the register control port: opcode values, sequencer
// FSM encoding and a helper that tells counted opcodes from single-shot ones.
package reg_ops_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CL  = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SR  = 3'd5;
  localparam logic [2:0] OP_SL  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // CL and LD always issue exactly one strobe; everything else uses cmd_cnt.
  function automatic logic op_is_counted(input logic [2:0] op);
    case (op)
      OP_CL, OP_LD: return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/reg_op_sequencer.sv
// Command-driven initiator for a general-purpose register's control port.
// One command per valid/ready handshake is expanded into a burst of one-hot
// strobes; shift commands stream the latched data bit by bit (SR LSB first,
// SL MSB first). All outputs are registered so the first strobe appears in
// the cycle right after the accepting edge.
// Optional feature macro: REG_SEQ_SHADOW_EN (shadow register + mismatch flag).
module reg_op_sequencer
  import reg_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] reg_out,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch
);

  localparam int STEP_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(DATA_WIDTH - 1);

  seq_state_e            state_r, state_nx_s;
  logic [2:0]            op_r, op_nx_s;
  logic [DATA_WIDTH-1:0] data_r, data_nx_s;
  logic [CNT_WIDTH-1:0]  rem_r, rem_nx_s, cnt_sel_s;
  logic [STEP_W-1:0]     step_r, step_nx_s;

  logic                  accept_s, issue_s;
  logic [2:0]            iss_op_s;
  logic [DATA_WIDTH-1:0] iss_data_s;
  logic [STEP_W-1:0]     iss_step_s;

  logic cl_s, ld_s, inc_s, dec_s, sr_s, sl_s, ir_s, il_s;
  logic [DATA_WIDTH-1:0] in_s;

  logic cmd_ready_r, busy_r, done_r;
  logic cl_r, ld_r, inc_r, dec_r, sr_r, sl_r, ir_r, il_r;
  logic [DATA_WIDTH-1:0] in_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: latch the command on accept, count the burst down, and
  // select which step (opcode, data, bit index) is issued in the next cycle.
  always_comb begin
    accept_s   = cmd_valid && cmd_ready_r;
    state_nx_s = state_r;
    op_nx_s    = op_r;
    data_nx_s  = data_r;
    rem_nx_s   = rem_r;
    step_nx_s  = step_r;
    cnt_sel_s  = {CNT_WIDTH{1'b0}};
    issue_s    = 1'b0;
    iss_op_s   = op_r;
    iss_data_s = data_r;
    iss_step_s = step_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_nx_s    = cmd_op;
          data_nx_s  = cmd_data;
          step_nx_s  = {STEP_W{1'b0}};
          iss_op_s   = cmd_op;
          iss_data_s = cmd_data;
          iss_step_s = {STEP_W{1'b0}};
          if (op_is_counted(cmd_op)) begin
            cnt_sel_s = cmd_cnt;
          end else begin
            cnt_sel_s = CNT_WIDTH'(1);
          end
          rem_nx_s = cnt_sel_s;
          if (cnt_sel_s == {CNT_WIDTH{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_EXEC;
            issue_s    = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (rem_r <= CNT_WIDTH'(1)) begin
          rem_nx_s   = {CNT_WIDTH{1'b0}};
          state_nx_s = ST_DONE;
        end else begin
          rem_nx_s   = rem_r - CNT_WIDTH'(1);
          step_nx_s  = (step_r == STEP_MAX) ? {STEP_W{1'b0}} : step_r + STEP_W'(1);
          iss_step_s = step_nx_s;
          issue_s    = 1'b1;
          state_nx_s = ST_EXEC;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Strobe decode for the step issued next cycle; at most one strobe is set.
  always_comb begin
    cl_s  = 1'b0;
    ld_s  = 1'b0;
    inc_s = 1'b0;
    dec_s = 1'b0;
    sr_s  = 1'b0;
    sl_s  = 1'b0;
    ir_s  = 1'b0;
    il_s  = 1'b0;
    in_s  = {DATA_WIDTH{1'b0}};
    if (issue_s) begin
      case (iss_op_s)
        OP_CL:  cl_s = 1'b1;
        OP_LD: begin
          ld_s = 1'b1;
          in_s = iss_data_s;
        end
        OP_INC: inc_s = 1'b1;
        OP_DEC: dec_s = 1'b1;
        OP_SR: begin
          sr_s = 1'b1;
          ir_s = iss_data_s[iss_step_s];
        end
        OP_SL: begin
          sl_s = 1'b1;
          il_s = iss_data_s[STEP_MAX - iss_step_s];
        end
        default: cl_s = 1'b0;
      endcase
    end else begin
      in_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Command context and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= 3'd0;
      data_r      <= {DATA_WIDTH{1'b0}};
      rem_r       <= {CNT_WIDTH{1'b0}};
      step_r      <= {STEP_W{1'b0}};
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cl_r        <= 1'b0;
      ld_r        <= 1'b0;
      inc_r       <= 1'b0;
      dec_r       <= 1'b0;
      sr_r        <= 1'b0;
      sl_r        <= 1'b0;
      ir_r        <= 1'b0;
      il_r        <= 1'b0;
      in_r        <= {DATA_WIDTH{1'b0}};
    end else begin
      op_r        <= op_nx_s;
      data_r      <= data_nx_s;
      rem_r       <= rem_nx_s;
      step_r      <= step_nx_s;
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      busy_r      <= (state_nx_s != ST_IDLE);
      done_r      <= (state_nx_s == ST_DONE);
      cl_r        <= cl_s;
      ld_r        <= ld_s;
      inc_r       <= inc_s;
      dec_r       <= dec_s;
      sr_r        <= sr_s;
      sl_r        <= sl_s;
      ir_r        <= ir_s;
      il_r        <= il_s;
      in_r        <= in_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign reg_cl    = cl_r;
  assign reg_ld    = ld_r;
  assign reg_inc   = inc_r;
  assign reg_dec   = dec_r;
  assign reg_sr    = sr_r;
  assign reg_sl    = sl_r;
  assign reg_ir    = ir_r;
  assign reg_il    = il_r;
  assign reg_in    = in_r;

`ifdef REG_SEQ_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow_r;
  logic                  mismatch_r;

  // Shadow copy of the driven register, compared against reg_out while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r   <= {DATA_WIDTH{1'b0}};
      mismatch_r <= 1'b0;
    end else begin
      if (cl_r) begin
        shadow_r <= {DATA_WIDTH{1'b0}};
      end else if (ld_r) begin
        shadow_r <= in_r;
      end else if (inc_r) begin
        shadow_r <= shadow_r + DATA_WIDTH'(1);
      end else if (dec_r) begin
        shadow_r <= shadow_r - DATA_WIDTH'(1);
      end else if (sr_r) begin
        shadow_r <= {ir_r, shadow_r[DATA_WIDTH-1:1]};
      end else if (sl_r) begin
        shadow_r <= {shadow_r[DATA_WIDTH-2:0], il_r};
      end else begin
        shadow_r <= shadow_r;
      end
      if (accept_s) begin
        mismatch_r <= 1'b0;
      end else if ((state_r == ST_DONE) && (reg_out != shadow_r)) begin
        mismatch_r <= 1'b1;
      end else begin
        mismatch_r <= mismatch_r;
      end
    end
  end

  assign mismatch = mismatch_r;
`else
  logic unused_reg_out_s;
  assign unused_reg_out_s = ^reg_out;
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed, table-driven bench for reg_op_sequencer. A behavioural model of
// the driven register feeds reg_out back, so final register values check the
// whole strobe burst. Define REG_SEQ_SHADOW_EN to also exercise the shadow check.
module tb_reg_op_sequencer;
  import reg_ops_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_cnt;
  logic [15:0] reg_out;
  logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
  logic [15:0] reg_in;
  logic        reg_ir, reg_il;
  logic        busy, done, mismatch;

  logic [15:0] model_q;
  logic        force_zero = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [7:0]  cnt;
    int          sel;   // expected strobe: 0 none, 1 cl, 2 ld, 3 inc, 4 dec, 5 sr, 6 sl
    int          k;     // expected number of EXEC cycles
    logic        poke;  // pulse cmd_valid while busy
    logic [15:0] q;     // expected register value afterwards
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  reg_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .reg_out(reg_out),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_in(reg_in), .reg_ir(reg_ir),
    .reg_il(reg_il), .busy(busy), .done(done), .mismatch(mismatch)
  );

  // Behavioural model of the general-purpose register being driven.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       model_q <= 16'h0000;
    else if (reg_cl)  model_q <= 16'h0000;
    else if (reg_ld)  model_q <= reg_in;
    else if (reg_inc) model_q <= model_q + 16'h0001;
    else if (reg_dec) model_q <= model_q - 16'h0001;
    else if (reg_sr)  model_q <= {reg_ir, model_q[15:1]};
    else if (reg_sl)  model_q <= {model_q[14:0], reg_il};
  end

  assign reg_out = force_zero ? 16'h0000 : model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle through the burst.
  task automatic run_vec(input vec_t v, input int idx);
    int strobe_bad = 0, ctl_bad = 0, done_cyc = 0, done_cnt = 0;
    logic [5:0]  strb, exp_strb;
    logic [15:0] exp_in;
    logic        exp_ir, exp_il;
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; cmd_cnt = v.cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= v.k + 3; c++) begin
      if (c > 1) @(negedge clk);
      strb     = {reg_sl, reg_sr, reg_dec, reg_inc, reg_ld, reg_cl};
      exp_strb = (c <= v.k && v.sel != 0) ? (6'b000001 << (v.sel - 1)) : 6'b000000;
      exp_in   = (v.sel == 2 && c <= v.k) ? v.data : 16'h0000;
      exp_ir   = (v.sel == 5 && c <= v.k) ? v.data[(c - 1) % 16] : 1'b0;
      exp_il   = (v.sel == 6 && c <= v.k) ? v.data[15 - ((c - 1) % 16)] : 1'b0;
      if (strb !== exp_strb || reg_in !== exp_in || reg_ir !== exp_ir || reg_il !== exp_il)
        strobe_bad++;
      if (busy !== (c <= v.k + 1) || cmd_ready !== (c >= v.k + 2)) ctl_bad++;
`ifndef REG_SEQ_SHADOW_EN
      if (mismatch !== 1'b0) ctl_bad++;
`endif
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (v.poke && c == 1) begin
        cmd_valid = 1'b1; cmd_op = OP_INC; cmd_cnt = 8'd1;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check($sformatf("v%0d strobe_cycles_bad", idx), strobe_bad, 0);
    check($sformatf("v%0d ctl_cycles_bad", idx), ctl_bad, 0);
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.k + 1);
    check($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d reg_value", idx), model_q, v.q);
  endtask

  initial begin
    vec_t post;
    tbl[0]  = '{op: OP_LD,  data: 16'hA5A5, cnt: 8'd7,   sel: 2, k: 1,   poke: 1'b0, q: 16'hA5A5};
    tbl[1]  = '{op: OP_CL,  data: 16'h0000, cnt: 8'd9,   sel: 1, k: 1,   poke: 1'b0, q: 16'h0000};
    tbl[2]  = '{op: OP_INC, data: 16'h0000, cnt: 8'd3,   sel: 3, k: 3,   poke: 1'b0, q: 16'h0003};
    tbl[3]  = '{op: OP_DEC, data: 16'h0000, cnt: 8'd0,   sel: 4, k: 0,   poke: 1'b0, q: 16'h0003};
    tbl[4]  = '{op: OP_SR,  data: 16'h8001, cnt: 8'd16,  sel: 5, k: 16,  poke: 1'b0, q: 16'h8001};
    tbl[5]  = '{op: OP_SL,  data: 16'h1234, cnt: 8'd16,  sel: 6, k: 16,  poke: 1'b0, q: 16'h1234};
    tbl[6]  = '{op: OP_NOP, data: 16'hFFFF, cnt: 8'd5,   sel: 0, k: 5,   poke: 1'b0, q: 16'h1234};
    tbl[7]  = '{op: 3'd7,   data: 16'hFFFF, cnt: 8'd2,   sel: 0, k: 2,   poke: 1'b0, q: 16'h1234};
    tbl[8]  = '{op: OP_DEC, data: 16'h0000, cnt: 8'd2,   sel: 4, k: 2,   poke: 1'b0, q: 16'h1232};
    tbl[9]  = '{op: OP_SR,  data: 16'h000A, cnt: 8'd4,   sel: 5, k: 4,   poke: 1'b0, q: 16'hA123};
    tbl[10] = '{op: OP_SL,  data: 16'h8000, cnt: 8'd20,  sel: 6, k: 20,  poke: 1'b0, q: 16'h0008};
    tbl[11] = '{op: OP_INC, data: 16'h0000, cnt: 8'd255, sel: 3, k: 255, poke: 1'b0, q: 16'h0107};
    tbl[12] = '{op: OP_DEC, data: 16'h0000, cnt: 8'd2,   sel: 4, k: 2,   poke: 1'b1, q: 16'h0105};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0000; cmd_cnt = 8'd0;
    #1;
    check("reset_outputs",
          {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, busy, done, cmd_ready, mismatch, reg_in},
          0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // Reset in the middle of an INC burst of 10, after 4 strobes.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_INC; cmd_cnt = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midburst_inc_active", {reg_inc, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("midburst_reset_outputs",
          {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, busy, done, cmd_ready, mismatch, reg_in},
          0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midburst_release_idle", {cmd_ready, busy, done, reg_inc}, 4'b1000);
    check("midburst_reg_cleared", model_q, 16'h0000);

    post = '{op: OP_LD, data: 16'h00FF, cnt: 8'd0, sel: 2, k: 1, poke: 1'b0, q: 16'h00FF};
    run_vec(post, 13);

`ifdef REG_SEQ_SHADOW_EN
    force_zero = 1'b1;
    run_vec(post, 14);
    check("shadow_mismatch_set", mismatch, 1);
    force_zero = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_NOP; cmd_cnt = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("shadow_mismatch_cleared", mismatch, 0);
    repeat (4) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
